// File: rtl/line_draw_ctrl.sv
// Bresenham line sequencer with full-screen clear arbitration, driving a single
// framebuffer write port over valid/ready handshakes.
module line_draw_ctrl #(
    parameter int W        = 11,
    parameter int COLOR_W  = 1,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [W-1:0]       x0,
    input  logic [W-1:0]       y0,
    input  logic [W-1:0]       x1,
    input  logic [W-1:0]       y1,
    input  logic [COLOR_W-1:0] req_color,
    input  logic               clear_req,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [W-1:0]       pix_x,
    output logic [W-1:0]       pix_y,
    output logic [COLOR_W-1:0] pix_color,
    output logic               busy,
    output logic               done,
    output logic [2:0]         dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid source holds its payload stable until that edge.

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DRAW, S_CLEAR, S_DONE} state_t;

    localparam logic [W-1:0] X_LAST = W'(SCREEN_W - 1);
    localparam logic [W-1:0] Y_LAST = W'(SCREEN_H - 1);

    state_t              state_q, state_d;
    logic                clr_pend_q, clr_pend_d;
    logic [W-1:0]        ex0_q, ey0_q, ex1_q, ey1_q;
    logic [W-1:0]        ex0_d, ey0_d, ex1_d, ey1_d;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic                steep_q, steep_d;
    logic                yneg_q, yneg_d;
    logic [W-1:0]        x_q, x_d, y_q, y_d, xb_q, xb_d;
    logic [W-1:0]        dx_q, dx_d, dy_q, dy_d;
    logic signed [W:0]   err_q, err_d;

    // Octant normalisation of the latched endpoints, consumed in SETUP.
    logic [W-1:0] adx, ady, sx0, sy0, sx1, sy1, ax, ay, bx, by, dx_c, dy_c;
    logic         steep_c, yneg_c;

    always_comb begin
        adx     = (ex1_q >= ex0_q) ? ex1_q - ex0_q : ex0_q - ex1_q;
        ady     = (ey1_q >= ey0_q) ? ey1_q - ey0_q : ey0_q - ey1_q;
        steep_c = ady > adx;
        sx0     = steep_c ? ey0_q : ex0_q;
        sy0     = steep_c ? ex0_q : ey0_q;
        sx1     = steep_c ? ey1_q : ex1_q;
        sy1     = steep_c ? ex1_q : ey1_q;
        if (sx0 > sx1) begin
            ax = sx1; ay = sy1; bx = sx0; by = sy0;
        end else begin
            ax = sx0; ay = sy0; bx = sx1; by = sy1;
        end
        dx_c   = bx - ax;
        dy_c   = (by >= ay) ? by - ay : ay - by;
        yneg_c = by < ay;
    end

    logic signed [W:0] err_n;

    always_comb begin
        state_d    = state_q;
        clr_pend_d = clr_pend_q | clear_req;
        ex0_d = ex0_q; ey0_d = ey0_q; ex1_d = ex1_q; ey1_d = ey1_q;
        color_d = color_q;
        steep_d = steep_q;
        yneg_d  = yneg_q;
        x_d = x_q; y_d = y_q; xb_d = xb_q;
        dx_d = dx_q; dy_d = dy_q;
        err_d = err_q;
        err_n = err_q;
        req_ready = 1'b0;
        pix_valid = 1'b0;
        pix_x     = '0;
        pix_y     = '0;
        pix_color = '0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = reset & ~clr_pend_q & ~clear_req;
                if (clr_pend_q || clear_req) begin
                    state_d    = S_CLEAR;
                    clr_pend_d = 1'b0;
                    x_d        = '0;
                    y_d        = '0;
                end else if (req_valid) begin
                    ex0_d = x0; ey0_d = y0; ex1_d = x1; ey1_d = y1;
                    color_d = req_color;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                steep_d = steep_c;
                yneg_d  = yneg_c;
                x_d     = ax;
                y_d     = ay;
                xb_d    = bx;
                dx_d    = dx_c;
                dy_d    = dy_c;
                err_d   = {2'b00, dx_c[W-1:1]};
                state_d = S_DRAW;
            end
            S_DRAW: begin
                pix_valid = 1'b1;
                pix_x     = steep_q ? y_q : x_q;
                pix_y     = steep_q ? x_q : y_q;
                pix_color = color_q;
                if (pix_ready) begin
                    if (x_q == xb_q) begin
                        state_d = S_DONE;
                    end else begin
                        x_d   = x_q + 1'b1;
                        err_n = err_q - $signed({1'b0, dy_q});
                        if (err_n[W]) begin
                            y_d   = yneg_q ? y_q - 1'b1 : y_q + 1'b1;
                            err_n = err_n + $signed({1'b0, dx_q});
                        end
                        err_d = err_n;
                    end
                end
            end
            S_CLEAR: begin
                pix_valid = 1'b1;
                pix_x     = x_q;
                pix_y     = y_q;
                if (pix_ready) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) state_d = S_DONE;
                        else               y_d = y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            clr_pend_q <= 1'b0;
            ex0_q <= '0; ey0_q <= '0; ex1_q <= '0; ey1_q <= '0;
            color_q <= '0;
            steep_q <= 1'b0;
            yneg_q  <= 1'b0;
            x_q <= '0; y_q <= '0; xb_q <= '0;
            dx_q <= '0; dy_q <= '0;
            err_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_pend_q <= clr_pend_d;
            ex0_q <= ex0_d; ey0_q <= ey0_d; ex1_q <= ex1_d; ey1_q <= ey1_d;
            color_q <= color_d;
            steep_q <= steep_d;
            yneg_q  <= yneg_d;
            x_q <= x_d; y_q <= y_d; xb_q <= xb_d;
            dx_q <= dx_d; dy_q <= dy_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Self-checking bench for line_draw_ctrl: directed scenarios plus randomized lines
// scored against a closed-form Bresenham reference held in an expected queue.
module tb_line_draw_ctrl;

    localparam int W  = 11;
    localparam int CW = 1;
    localparam int SW = 4;
    localparam int SH = 2;
    localparam int PW = 2 * W + CW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          clear_req = 1'b0;
    logic          pix_ready = 1'b1;
    logic [W-1:0]  x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [CW-1:0] req_color = '0;
    logic          req_ready, pix_valid, busy, done;
    logic [W-1:0]  pix_x, pix_y;
    logic [CW-1:0] pix_color;
    logic [2:0]    dbg_state;

    int n_tests  = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    bit rdy_rand = 1'b0;
    bit force_stall = 1'b0;
    logic [PW-1:0] exp_q[$];

    line_draw_ctrl #(.W(W), .COLOR_W(CW), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .req_color(req_color),
        .clear_req(clear_req),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / reset / sink back-pressure
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        pix_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : !force_stall;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference model: pixel k of the normalised line has y offset equal to the
    // smallest m >= 0 with dx/2 - k*dy + m*dx >= 0
    task automatic push_line(input int ux0, input int uy0, input int ux1, input int uy1, input int c);
        int ax, ay, bx, by, t, dx, dy, h, ys, n, m, px, py;
        bit steep;
        steep = ((uy1 > uy0) ? uy1 - uy0 : uy0 - uy1) > ((ux1 > ux0) ? ux1 - ux0 : ux0 - ux1);
        if (steep) begin
            ax = uy0; ay = ux0; bx = uy1; by = ux1;
        end else begin
            ax = ux0; ay = uy0; bx = ux1; by = uy1;
        end
        if (ax > bx) begin
            t = ax; ax = bx; bx = t;
            t = ay; ay = by; by = t;
        end
        dx = bx - ax;
        dy = (by > ay) ? by - ay : ay - by;
        ys = (by >= ay) ? 1 : -1;
        h  = dx / 2;
        for (int k = 0; k <= dx; k++) begin
            n  = k * dy - h;
            m  = (n <= 0) ? 0 : (n + dx - 1) / dx;
            px = ax + k;
            py = ay + ys * m;
            if (steep) exp_q.push_back({py[W-1:0], px[W-1:0], c[CW-1:0]});
            else       exp_q.push_back({px[W-1:0], py[W-1:0], c[CW-1:0]});
        end
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < SH; yy++)
            for (int xx = 0; xx < SW; xx++)
                exp_q.push_back({xx[W-1:0], yy[W-1:0], {CW{1'b0}}});
    endtask

    // drivers
    task automatic drive_req(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
        @(posedge clk); #1;
        x0 = ax0[W-1:0]; y0 = ay0[W-1:0]; x1 = ax1[W-1:0]; y1 = ay1[W-1:0];
        req_color = c[CW-1:0];
        req_valid = 1'b1;
    endtask

    task automatic wait_accept(input int limit);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!req_ready && i < limit);
        check("req_accepted", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic send_line(input int ax0, input int ay0, input int ax1, input int ay1, input int c);
        drive_req(ax0, ay0, ax1, ay1, c);
        wait_accept(100);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!done && i < limit);
        check("done_seen", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // scoreboard / monitor
    logic [PW-1:0] cur_pix, prev_pix;
    bit prev_stall = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            cur_pix = {pix_x, pix_y, pix_color};
            if (prev_stall) check("stall_hold", {pix_valid, cur_pix}, {1'b1, prev_pix});
            if (pix_valid && pix_ready) begin
                check("pix_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("pix_value", cur_pix, exp_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("done_no_pix", pix_valid, 0);
            end
            prev_stall = pix_valid && !pix_ready;
            prev_pix   = cur_pix;
        end
    end

    // stimulus
    int d0, lim;
    int rx0, ry0, rx1, ry1;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_req_ready", req_ready, 0);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_release_ready", req_ready, 1);

        // 1: horizontal line, exact latency
        push_line(0, 0, 4, 0, 1);
        send_line(0, 0, 4, 0, 1);
        @(negedge clk);
        check("t1_setup_valid", pix_valid, 0);
        check("t1_setup_busy", busy, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t1_pix_valid", pix_valid, 1);
            check("t1_pix_x", pix_x, k);
        end
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_done_valid", pix_valid, 0);
        @(negedge clk);
        check("t1_ready_after", req_ready, 1);
        check("t1_done_low", done, 0);
        check("t1_queue", exp_q.size(), 0);

        // 2: steep reversed line
        push_line(2, 5, 0, 0, 0);
        send_line(2, 5, 0, 0, 0);
        wait_done(50);

        // 3: stall on the third pixel
        push_line(0, 0, 4, 2, 1);
        send_line(0, 0, 4, 2, 1);
        repeat (3) @(posedge clk);
        #1 force_stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t3_stall_valid", pix_valid, 1);
            check("t3_stall_x", pix_x, 2);
            check("t3_stall_y", pix_y, 1);
        end
        @(posedge clk); #1 force_stall = 1'b0;
        wait_done(50);

        // 4: degenerate line
        push_line(3, 3, 3, 3, 1);
        send_line(3, 3, 3, 3, 1);
        wait_done(50);

        // 5: clear wins arbitration, then pending clear after a line
        push_clear();
        push_line(1, 1, 3, 2, 1);
        d0 = done_cnt;
        drive_req(1, 1, 3, 2, 1);
        clear_req = 1'b1;
        @(negedge clk);
        check("t5_arb_ready_low", req_ready, 0);
        @(posedge clk); #1 clear_req = 1'b0;
        wait_accept(100);
        check("t5_clear_done_first", done_cnt - d0, 1);
        wait_done(50);

        push_line(0, 0, 7, 3, 1);
        push_clear();
        push_line(5, 5, 6, 5, 1);
        d0 = done_cnt;
        send_line(0, 0, 7, 3, 1);
        repeat (3) @(negedge clk);
        pulse_clear();
        x0 = 5; y0 = 5; x1 = 6; y1 = 5; req_color = 1;
        req_valid = 1'b1;
        wait_accept(200);
        check("t5_line_and_clear_done", done_cnt - d0, 2);
        wait_done(50);

        // 6: reset mid-line drops line and pending clear
        push_line(0, 0, 9, 0, 1);
        send_line(0, 0, 9, 0, 1);
        repeat (4) @(negedge clk);
        pulse_clear();
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_async_valid", pix_valid, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_done", done, 0);
        check("t6_async_ready", req_ready, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        @(negedge clk);
        check("t6_ready_after", req_ready, 1);
        repeat (5) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_idle_busy", busy, 0);

        // randomized lines with back-pressure and occasional clears
        rdy_rand = 1'b1;
        for (int i = 0; i < 36; i++) begin
            lim = (i % 12 == 11) ? (1 << W) - 1 : 40;
            rx0 = $urandom_range(0, lim);
            ry0 = $urandom_range(0, lim);
            rx1 = $urandom_range(0, lim);
            ry1 = $urandom_range(0, lim);
            d0  = $urandom_range(0, 1);
            push_line(rx0, ry0, rx1, ry1, d0);
            send_line(rx0, ry0, rx1, ry1, d0);
            wait_done(10000);
            if (i % 8 == 7) begin
                push_clear();
                pulse_clear();
                wait_done(200);
            end
        end
        rdy_rand = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
